// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an incoming PWM signal in
// clk cycles, publishes each complete period as a coherent pair with a
// one-cycle valid strobe, and flags loss of activity with a timeout pulse.
module pwm_capture #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  input  logic             enable,
  output logic [WIDTH-1:0] period_out,
  output logic [WIDTH-1:0] high_out,
  output logic             valid,
  output logic             timeout,
  output logic             stuck_level
);

  localparam logic [WIDTH-1:0] TO_CNT = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t           state_q;
  logic             sync1_q, sync2_q, prev_q;
  logic [WIDTH-1:0] cnt_q, high_cap_q, period_q, high_q;
  logic             valid_q, timeout_q, stuck_q;

  logic             rise, fall, at_to;
  logic [WIDTH-1:0] cnt_inc;

  // Two-flop synchronizer plus a previous-sample register. prev tracks the
  // synchronized level in every state, so a level already present when
  // measurement starts never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= pwm_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise  = sync2_q & ~prev_q;
  assign fall  = ~sync2_q & prev_q;
  assign at_to = (cnt_q == TO_CNT);
  // Saturate at the timeout value so a fall landing exactly on the limit
  // cannot wrap the counter before LOW gets to declare the timeout.
  assign cnt_inc = at_to ? cnt_q : cnt_q + ONE;

  // Measurement FSM with registered outputs. A rise coinciding with the
  // timeout count is treated as a measurement, not a timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      high_cap_q <= '0;
      period_q   <= '0;
      high_q     <= '0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
      stuck_q    <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      if (!enable) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (rise) begin
              state_q <= HIGH;
              cnt_q   <= ONE;
            end else begin
              cnt_q   <= '0;
            end
          end
          HIGH: begin
            if (fall) begin
              high_cap_q <= cnt_q;
              state_q    <= LOW;
              cnt_q      <= cnt_inc;
            end else if (at_to) begin
              timeout_q <= 1'b1;
              stuck_q   <= sync2_q;
              state_q   <= IDLE;
              cnt_q     <= '0;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          LOW: begin
            if (rise) begin
              // Closing rise: publish the pair and start the next period.
              period_q <= cnt_q;
              high_q   <= high_cap_q;
              valid_q  <= 1'b1;
              cnt_q    <= ONE;
              state_q  <= HIGH;
            end else if (at_to) begin
              timeout_q <= 1'b1;
              stuck_q   <= sync2_q;
              state_q   <= IDLE;
              cnt_q     <= '0;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign period_out  = period_q;
  assign high_out    = high_q;
  assign valid       = valid_q;
  assign timeout     = timeout_q;
  assign stuck_level = stuck_q;

endmodule
